layer_sched_ctrl: RTL and testbench
===================================

// Module: layer_sched_ctrl
// PURPOSE
// Layer/iteration sequencer for the layered QC-LDPC decoder. Drives the check-message
// store (read strobe load_to_CNU, write strobe storage, address reset f_one_iteration,
// clear rst_r) and the CNU pipeline, one layer at a time, for up to max_iter iterations.
// Sits upstream of the check-message store and CNU; started by the top-level decode FSM.
// PARAMETERS
// LAYERS   16  block rows per iteration (store address is 4 bits, so LAYERS<=16)
// CNU_LAT  3   cycles from LLRr_in registered to LLRr_out valid (>=1)
// ITER_W   5   width of iteration counter / max_iter
// PORTS
// clk              in   1       system clock, rising edge
// rst_n            in   1       async active-low reset
// start            in   1       1-cycle request to start a codeword; ignored while busy
// abort            in   1       sync abort; ends decode without done
// max_iter         in   ITER_W  iteration limit, sampled on accepted start; 0 treated as 1
// early_stop       in   1       syndrome-all-zero flag, sampled only in ITER_END
// rst_r            out  1       active-low clear of the check-message store
// load_to_CNU      out  1       read current layer from store into CNU input register
// storage          out  1       write CNU result to store, advance store address
// f_one_iteration  out  1       reset store address to layer 0
// layer            out  4       current layer index 0..LAYERS-1
// iter_cnt         out  ITER_W  completed iterations of current/last decode
// busy             out  1       high from accepted start until the DONE cycle inclusive
// done             out  1       1-cycle pulse, decode finished
// converged        out  1       1 if last decode ended via early_stop; held until next start
// BEHAVIOUR
// - Reset: state IDLE; rst_r=1; load_to_CNU=storage=f_one_iteration=done=busy=0;
//   layer=0; iter_cnt=0; converged=0; max_iter latch=0. All outputs registered (Moore).
// - States: IDLE, CLR, LOAD, WAIT, STORE, ITER_END, DONE.
// - IDLE: start=1 -> CLR; latch max_iter (0 -> 1); iter_cnt<=0; converged<=0.
// - CLR (1 cycle): rst_r=0 and f_one_iteration=1 together; layer=0 -> LOAD.
// - LOAD (1 cycle): load_to_CNU=1 -> WAIT; wait counter loaded with CNU_LAT-1.
// - WAIT (CNU_LAT cycles): all strobes low; counter reaches 0 -> STORE.
// - STORE (1 cycle): storage=1. layer<LAYERS-1: layer++ -> LOAD;
//   else -> ITER_END. Load and store of one layer never overlap (store addr shared).
// - ITER_END (1 cycle): f_one_iteration=1 (never coincident with storage); layer<=0;
//   iter_cnt++. early_stop=1 -> converged<=1, DONE; else if iter_cnt+1==max_iter -> DONE;
//   else -> LOAD. early_stop takes priority over the limit when both are true.
// - DONE (1 cycle): done=1, busy=1 -> IDLE. start in DONE is ignored.
// - Per layer CNU_LAT+2 cycles; per iteration LAYERS*(CNU_LAT+2)+1 cycles.
// - abort=1 in any non-IDLE state: next state IDLE, strobes low, no done, converged=0,
//   iter_cnt keeps its value; abort has priority over start/early_stop.
// - rst_n low mid-decode: immediately to reset values; store contents are cleared
//   separately by its own reset.
// - iter_cnt saturates at 2^ITER_W-1 (unreachable when max_iter fits ITER_W).
// TESTING (LAYERS=16, CNU_LAT=3: 5 cycles/layer, 81 cycles/iter; start in cycle 0)
// 1 start, max_iter=2, early_stop=0 -> CLR in cycle 1; load_to_CNU in cycles 2,7,..;
//   32 load and 32 storage pulses; f_one_iteration in cycles 1,82,163; done in 164; iter_cnt=2.
// 2 max_iter=5, early_stop=1 in 2nd ITER_END -> done in cycle 164, converged=1, iter_cnt=2.
// 3 max_iter=0 -> behaves as 1: done in cycle 83, 16 storage pulses.
// 4 abort in cycle 40 -> IDLE in cycle 41, no done pulse, all strobes 0, busy=0.
// 5 rst_n low in cycle 50 -> all outputs reset asynchronously; start ignored while rst_n low.
// 6 start repeated while busy and in DONE cycle -> ignored; new start after IDLE accepted.

Source files
------------

// File: rtl/layer_sched_if.sv
// Control bundle between the top-level decode FSM (master) and the
// layer/iteration sequencer (slave), including the check-message store strobes.
interface layer_sched_if #(
  parameter int ITER_W = 5
);
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] max_iter;
  logic              early_stop;
  logic              rst_r;
  logic              load_to_CNU;
  logic              storage;
  logic              f_one_iteration;
  logic [3:0]        layer;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              done;
  logic              converged;

  modport master (
    output start, abort, max_iter, early_stop,
    input  rst_r, load_to_CNU, storage, f_one_iteration, layer, iter_cnt,
           busy, done, converged
  );

  modport slave (
    input  start, abort, max_iter, early_stop,
    output rst_r, load_to_CNU, storage, f_one_iteration, layer, iter_cnt,
           busy, done, converged
  );
endinterface

// File: rtl/layer_sched_ctrl.sv
// Layer/iteration sequencer for the layered QC-LDPC decoder. Walks the
// check-message store one layer at a time (load, wait for the CNU, store) for
// up to max_iter iterations, with early termination on a zero syndrome.
// LAYERS must not exceed 16 because the store address is 4 bits wide.
module layer_sched_ctrl #(
  parameter int LAYERS  = 16,
  parameter int CNU_LAT = 3,
  parameter int ITER_W  = 5
) (
  input logic          clk,
  input logic          rst_n,
  layer_sched_if.slave bus
);

  localparam int WAIT_W = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;
  localparam logic [3:0] LAST_LAYER = 4'(LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, WAIT, STORE, ITER_END, DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ITER_W-1:0] max_lat;
  logic [ITER_W-1:0] iter_cnt;
  logic [3:0]        layer;
  logic              rst_r, load_to_cnu, storage, f_one, busy, done, converged;

  // One more than the completed-iteration count, one bit wider so the
  // limit compare and the saturation never wrap.
  logic [ITER_W:0] iter_next;
  assign iter_next = {1'b0, iter_cnt} + 1'b1;

  // Sequencer: state and every output are registered together, so each
  // transition also sets the strobes seen during the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      max_lat     <= '0;
      iter_cnt    <= '0;
      layer       <= '0;
      rst_r       <= 1'b1;
      load_to_cnu <= 1'b0;
      storage     <= 1'b0;
      f_one       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
    end else begin
      // NOTE: strobes default to their idle level here with non-blocking
      // assignments; the case below overrides only the one being raised.
      rst_r       <= 1'b1;
      load_to_cnu <= 1'b0;
      storage     <= 1'b0;
      f_one       <= 1'b0;
      done        <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        converged <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.start) begin
            state     <= CLR;
            max_lat   <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
            iter_cnt  <= '0;
            converged <= 1'b0;
            busy      <= 1'b1;
            layer     <= '0;
            rst_r     <= 1'b0;
            f_one     <= 1'b1;
          end
          CLR: begin
            state       <= LOAD;
            load_to_cnu <= 1'b1;
          end
          LOAD: begin
            state    <= WAIT;
            wait_cnt <= WAIT_W'(CNU_LAT - 1);
          end
          WAIT: if (wait_cnt == '0) begin
            state   <= STORE;
            storage <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
          STORE: if (layer == LAST_LAYER) begin
            state <= ITER_END;
            f_one <= 1'b1;
          end else begin
            layer       <= layer + 1'b1;
            state       <= LOAD;
            load_to_cnu <= 1'b1;
          end
          ITER_END: begin
            layer    <= '0;
            iter_cnt <= iter_next[ITER_W] ? '1 : iter_next[ITER_W-1:0];
            if (bus.early_stop) begin
              converged <= 1'b1;
              state     <= DONE;
              done      <= 1'b1;
            end else if (iter_next == {1'b0, max_lat}) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= LOAD;
              load_to_cnu <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rst_r           = rst_r;
  assign bus.load_to_CNU     = load_to_cnu;
  assign bus.storage         = storage;
  assign bus.f_one_iteration = f_one;
  assign bus.layer           = layer;
  assign bus.iter_cnt        = iter_cnt;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.converged       = converged;

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Bench for layer_sched_ctrl: table of decode scenarios driven through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_layer_sched_ctrl;
  localparam int LAYERS  = 16;
  localparam int CNU_LAT = 3;
  localparam int ITER_W  = 5;
  localparam int LC      = CNU_LAT + 2;      // cycles per layer
  localparam int IC      = LAYERS * LC + 1;  // cycles per iteration

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_sched_if #(.ITER_W(ITER_W)) bus ();

  layer_sched_ctrl #(.LAYERS(LAYERS), .CNU_LAT(CNU_LAT), .ITER_W(ITER_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int max_iter;
    int es_iter;    // ITER_END index (1-based) carrying early_stop, 0 = never
    int abort_cyc;  // cycle carrying abort, -1 = never
    int re_a;       // cycles carrying a repeated start, -1 = never
    int re_b;
    int exp_done;   // done cycle, -1 = no done pulse
    int exp_end;    // first cycle with busy low
    int exp_iter;
    int exp_conv;
    int exp_loads;
    int exp_stores;
    int exp_f1;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.early_stop = 1'b0;
  endtask

  // One decode started in cycle 0; outputs observed #1 after each edge.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int c, loads, stores, f1s, viol, done_cyc, end_cyc, p, q;
    bit ended;
    loads = 0; stores = 0; f1s = 0; viol = 0; done_cyc = -1; end_cyc = -1;
    ended = 1'b0;
    exp_q.push_back(v);
    bus.max_iter = ITER_W'(v.max_iter);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.max_iter = '1;  // must have been latched at start
    c = 1;
    for (int k = 0; k < 1000; k++) begin
      if (!bus.busy) begin
        end_cyc = c;
        ended = 1'b1;
        break;
      end
      if (bus.load_to_CNU) begin
        loads++;
        p = (c - 2) % IC;
        if (c < 2 || p % LC != 0 || int'(bus.layer) != p / LC) viol++;
      end
      if (bus.storage) begin
        stores++;
        q = c - 3 - CNU_LAT;
        if (q < 0 || (q % IC) % LC != 0 || int'(bus.layer) != (q % IC) / LC) viol++;
        if (bus.load_to_CNU) viol++;
      end
      if (bus.f_one_iteration) begin
        f1s++;
        if ((c - 1) % IC != 0 || bus.storage || bus.load_to_CNU) viol++;
      end
      if (!bus.rst_r && c != 1) viol++;
      if (c == 1 && (bus.rst_r || !bus.f_one_iteration || bus.layer != 4'd0)) viol++;
      if (bus.done) done_cyc = c;
      bus.early_stop = (v.es_iter > 0 && c == 1 + IC * v.es_iter);
      bus.abort = (c == v.abort_cyc);
      bus.start = (c == v.re_a || c == v.re_b);
      tick();
      c++;
    end
    clear_inputs();
    check($sformatf("v%0d ended_in_budget", idx), int'(ended), 1);
    e = exp_q.pop_front();
    check($sformatf("v%0d done_cycle", idx), done_cyc, e.exp_done);
    check($sformatf("v%0d idle_cycle", idx), end_cyc, e.exp_end);
    check($sformatf("v%0d iter_cnt", idx), int'(bus.iter_cnt), e.exp_iter);
    check($sformatf("v%0d converged", idx), int'(bus.converged), e.exp_conv);
    check($sformatf("v%0d load_pulses", idx), loads, e.exp_loads);
    check($sformatf("v%0d storage_pulses", idx), stores, e.exp_stores);
    check($sformatf("v%0d f_one_pulses", idx), f1s, e.exp_f1);
    check($sformatf("v%0d timing_violations", idx), viol, 0);
    check($sformatf("v%0d idle_strobes", idx),
          int'({bus.rst_r, bus.load_to_CNU, bus.storage, bus.f_one_iteration, bus.done}),
          5'b10000);
  endtask

  initial begin
    //           max es abort reA reB done end it cv ld  st  f1
    vecs[0] = '{2, 0, -1,  -1, -1, 164, 165, 2, 0, 32, 32, 3};
    vecs[1] = '{5, 2, -1,  -1, -1, 164, 165, 2, 1, 32, 32, 3};
    vecs[2] = '{0, 0, -1,  -1, -1,  83,  84, 1, 0, 16, 16, 2};
    vecs[3] = '{3, 0, 40,  -1, -1,  -1,  41, 0, 0,  8,  7, 1};
    vecs[4] = '{3, 0, 100, -1, -1,  -1, 101, 1, 0, 20, 19, 2};
    vecs[5] = '{1, 0, -1,  10, 83,  83,  84, 1, 0, 16, 16, 2};
    vecs[6] = '{1, 1, -1,  -1, -1,  83,  84, 1, 1, 16, 16, 2};
    vecs[7] = '{3, 0, -1,  -1, -1, 245, 246, 3, 0, 48, 48, 4};

    clear_inputs();
    bus.max_iter = '0;
    #12;
    check("reset outputs",
          int'({bus.rst_r, bus.load_to_CNU, bus.storage, bus.f_one_iteration,
                bus.busy, bus.done, bus.converged}), 7'b1000000);
    check("reset layer", int'(bus.layer), 0);
    check("reset iter_cnt", int'(bus.iter_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("idle without start busy", int'(bus.busy), 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // Asynchronous reset in the middle of the second iteration (cycle 90).
    bus.max_iter = ITER_W'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 90; c++) tick();
    check("pre-reset layer", int'(bus.layer), (90 - 2 - IC) / LC);
    check("pre-reset iter_cnt", int'(bus.iter_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs",
          int'({bus.rst_r, bus.load_to_CNU, bus.storage, bus.f_one_iteration,
                bus.busy, bus.done, bus.converged}), 7'b1000000);
    check("async reset layer", int'(bus.layer), 0);
    check("async reset iter_cnt", int'(bus.iter_cnt), 0);
    bus.start = 1'b1;
    tick();
    tick();
    check("start during reset busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("post-reset busy", int'(bus.busy), 0);
    run_vec(8, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
